// File: rtl/matmul_if.sv
// matmul_if: control/address bundle between a job requester and matmul_seq.
//   Requester -> sequencer : start, abort, dim_m/n/k, base_a/b/c
//   Sequencer -> memories/MAC : rd_en, a_addr, b_addr, mac_en, mac_clr,
//                                wr_en, c_addr
//   Sequencer -> requester : busy, done, err
// master modport is the requester side, slave modport is the sequencer.
interface matmul_if #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
);
  logic              start;
  logic              abort;
  logic [DIM_W-1:0]  dim_m;
  logic [DIM_W-1:0]  dim_n;
  logic [DIM_W-1:0]  dim_k;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_en;
  logic              mac_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] c_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, dim_m, dim_n, dim_k, base_a, base_b, base_c,
    input  rd_en, a_addr, b_addr, mac_en, mac_clr, wr_en, c_addr,
           busy, done, err
  );

  modport slave (
    input  start, abort, dim_m, dim_n, dim_k, base_a, base_b, base_c,
    output rd_en, a_addr, b_addr, mac_en, mac_clr, wr_en, c_addr,
           busy, done, err
  );
endinterface

// File: rtl/matmul_seq.sv
// matmul_seq: address/strobe sequencer for C(MxN) = A(MxK) * B(KxN).
// Walks i (outer), j (middle), k (inner) with incremental pointers, issuing
// one A/B operand read per cycle, then drives MAC enable/clear one cycle
// later and the C write two cycles later.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - matmul_if.slave (job request, operand/result strobes, status)
module matmul_seq #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  matmul_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  state_t            state_q, state_d;
  logic              drain_q, drain_d;
  logic              err_q, err_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d, a_row_q, a_row_d;
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d, b_col_q, b_col_d, base_b_q, base_b_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
  logic              mac_p1_q, mac_p1_d, clr_p1_q, clr_p1_d;
  logic              wr_p1_q, wr_p1_d, wr_p2_q, wr_p2_d;
  logic [ADDR_W-1:0] c_p1_q, c_p1_d, c_p2_q, c_p2_d;

  logic rd, last_k, last_j, last_i;

  // State register: control and visible addresses are reset, job data is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      drain_q  <= 1'b0;
      err_q    <= 1'b0;
      mac_p1_q <= 1'b0;
      clr_p1_q <= 1'b0;
      wr_p1_q  <= 1'b0;
      wr_p2_q  <= 1'b0;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      c_p2_q   <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
      mac_p1_q <= mac_p1_d;
      clr_p1_q <= clr_p1_d;
      wr_p1_q  <= wr_p1_d;
      wr_p2_q  <= wr_p2_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      c_p2_q   <= c_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    m_q      <= m_d;
    n_q      <= n_d;
    k_q      <= k_d;
    i_q      <= i_d;
    j_q      <= j_d;
    kk_q     <= kk_d;
    a_row_q  <= a_row_d;
    b_col_q  <= b_col_d;
    base_b_q <= base_b_d;
    c_ptr_q  <= c_ptr_d;
    c_p1_q   <= c_p1_d;
  end

  // Next-state and pointer logic.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    err_d    = 1'b0;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    kk_d     = kk_q;
    a_ptr_d  = a_ptr_q;
    a_row_d  = a_row_q;
    b_ptr_d  = b_ptr_q;
    b_col_d  = b_col_q;
    base_b_d = base_b_q;
    c_ptr_d  = c_ptr_q;

    rd     = (state_q == S_ISSUE);
    last_k = (kk_q == k_q - ONE_D);
    last_j = (j_q == n_q - ONE_D);
    last_i = (i_q == m_q - ONE_D);

    // Stage p1: operand data arrives, MAC strobes; stage p2: C write.
    mac_p1_d = rd;
    clr_p1_d = rd && (kk_q == '0);
    wr_p1_d  = rd && last_k;
    c_p1_d   = wr_p1_d ? c_ptr_q : c_p1_q;
    wr_p2_d  = wr_p1_q;
    c_p2_d   = wr_p1_q ? c_p1_q : c_p2_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dim_m == '0 || bus.dim_n == '0 || bus.dim_k == '0) begin
            err_d = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            m_d      = bus.dim_m;
            n_d      = bus.dim_n;
            k_d      = bus.dim_k;
            i_d      = '0;
            j_d      = '0;
            kk_d     = '0;
            a_ptr_d  = bus.base_a;
            a_row_d  = bus.base_a;
            b_ptr_d  = bus.base_b;
            b_col_d  = bus.base_b;
            base_b_d = bus.base_b;
            c_ptr_d  = bus.base_c;
          end
        end
      end
      S_ISSUE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!last_k) begin
          kk_d    = kk_q + ONE_D;
          a_ptr_d = a_ptr_q + ADDR_W'(1);
          b_ptr_d = b_ptr_q + ADDR_W'(n_q);
        end else begin
          kk_d    = '0;
          c_ptr_d = c_ptr_q + ADDR_W'(1);
          if (!last_j) begin
            // Next column of B, same row of A.
            j_d     = j_q + ONE_D;
            a_ptr_d = a_row_q;
            b_col_d = b_col_q + ADDR_W'(1);
            b_ptr_d = b_col_q + ADDR_W'(1);
          end else begin
            j_d     = '0;
            b_col_d = base_b_q;
            b_ptr_d = base_b_q;
            if (!last_i) begin
              i_d     = i_q + ONE_D;
              a_row_d = a_row_q + ADDR_W'(k_q);
              a_ptr_d = a_row_q + ADDR_W'(k_q);
            end else begin
              state_d = S_DRAIN;
              drain_d = 1'b0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (drain_q) begin
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An abort kills everything still in flight.
    if ((state_q == S_ISSUE || state_q == S_DRAIN) && bus.abort) begin
      mac_p1_d = 1'b0;
      clr_p1_d = 1'b0;
      wr_p1_d  = 1'b0;
      wr_p2_d  = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    bus.rd_en   = (state_q == S_ISSUE);
    bus.a_addr  = a_ptr_q;
    bus.b_addr  = b_ptr_q;
    bus.mac_en  = mac_p1_q;
    bus.mac_clr = clr_p1_q;
    bus.wr_en   = wr_p2_q;
    bus.c_addr  = c_p2_q;
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_DONE);
    bus.err     = err_q;
  end

endmodule
